// File: rtl/encoder_8to3_seq_if.sv
// -----------------------------------------------------------------------------
// encoder_8to3_seq_if
//
// Purpose:
//    Bundles the request/handshake signals of the sequential 8-to-3 encoder so
//    that the producer/consumer side and the encoder share one port.
//
// Parameters:
//    N  - request vector width (only 8 is supported by the encoder)
//    W  - index width, clog2(N)
//
// Signals:
//    start  - capture request, sampled only while busy is low
//    d      - request vector, sampled on the start edge
//    ready  - consumer accepts the current index
//    valid  - y holds a pending index
//    y      - current index (0 whenever valid is low)
//    busy   - a capture is in progress
//    done   - one-cycle pulse at the end of each capture
//    count  - popcount of the captured vector, W+1 bits wide
//    zero   - the captured vector was all zeros
//
// Modports:
//    master - the side that issues requests and consumes indices
//    slave  - the encoder itself
// -----------------------------------------------------------------------------
interface encoder_8to3_seq_if #(
   parameter int N = 8,
   parameter int W = 3
);
   logic          start;
   logic [N-1:0]  d;
   logic          ready;
   logic          valid;
   logic [W-1:0]  y;
   logic          busy;
   logic          done;
   logic [W:0]    count;
   logic          zero;

   modport master (
      output start, d, ready,
      input  valid, y, busy, done, count, zero
   );

   modport slave (
      input  start, d, ready,
      output valid, y, busy, done, count, zero
   );
endinterface

// File: rtl/encoder_8to3_seq.sv
// -----------------------------------------------------------------------------
// encoder_8to3_seq
//
// Purpose:
//    Sequential 8-to-3 encoder. On start it captures an 8-bit request vector
//    into a shadow register and then emits the binary index of every set bit,
//    one index per valid/ready handshake. After the last index it pulses done
//    for one cycle. The popcount of the captured vector and an all-zero flag
//    are held until the next capture.
//
// Configuration:
//    ENCODER_8TO3_MSB_FIRST_EN - when defined, indices are emitted highest bit
//    first (descending). When undefined (default), lowest bit first.
//    count, zero, handshake and timing are identical in both builds.
//
// Ports:
//    clk  - single clock, rising edge active
//    rst  - asynchronous, active-high reset; aborts any capture in flight
//    bus  - encoder_8to3_seq_if.slave:
//             in : start, d, ready
//             out: valid, y, busy, done, count, zero (all registered)
//
// Parameters:
//    N (8) and W (3); only N = 8, W = 3 is supported.
// -----------------------------------------------------------------------------
module encoder_8to3_seq #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   encoder_8to3_seq_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of set bits; one extra bit so an all-ones vector does not wrap.
   function automatic logic [W:0] popcount(input logic [N-1:0] v);
      logic [W:0] acc;
      acc = {(W+1){1'b0}};
      for (int i = 0; i < N; i++) begin
         acc = acc + {{W{1'b0}}, v[i]};
      end
      return acc;
   endfunction

   // Priority encode of the shadow register. The loop direction makes the
   // last matching bit win, which selects lowest- or highest-first order.
   function automatic logic [W-1:0] pick_index(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = {W{1'b0}};
`ifdef ENCODER_8TO3_MSB_FIRST_EN
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            idx = W'(i);
         end else begin
            idx = idx;
         end
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = W'(i);
         end else begin
            idx = idx;
         end
      end
`endif
      return idx;
   endfunction

   // One-hot mask for a bit index, used to retire the bit just handed out.
   function automatic logic [N-1:0] index_mask(input logic [W-1:0] idx);
      logic [N-1:0] one;
      one = {{(N-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   state_t        state_q, state_d;
   logic [N-1:0]  s_q, s_d;
   logic [W:0]    count_q, count_d;
   logic          zero_q, zero_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  y_q, y_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state, shadow register and registered-output computation.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      count_d = count_q;
      zero_d  = zero_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               s_d     = bus.d;
               count_d = popcount(bus.d);
               zero_d  = (bus.d == {N{1'b0}});
               // An empty vector has nothing to hand out: go straight to DONE.
               if (bus.d == {N{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SCAN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SCAN: begin
            if (valid_q && bus.ready) begin
               s_d = s_q & ~index_mask(pick_index(s_q));
               if (s_d == {N{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SCAN;
               end
            end else begin
               state_d = ST_SCAN;
            end
         end

         ST_DONE: begin
            // start is deliberately not looked at here, so every capture is
            // followed by at least one IDLE cycle.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            s_d     = {N{1'b0}};
         end
      endcase

      // Outputs are decoded from the next state so they can be registered
      // alongside it without adding a cycle of latency.
      valid_d = (state_d == ST_SCAN);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
      if (state_d == ST_SCAN) begin
         y_d = pick_index(s_d);
      end else begin
         y_d = {W{1'b0}};
      end
   end

   // FSM state, shadow register and output flops; reset aborts any capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_q     <= {N{1'b0}};
         count_q <= {(W+1){1'b0}};
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
         y_q     <= {W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         count_q <= count_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.valid = valid_q;
   assign bus.y     = y_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.count = count_q;
   assign bus.zero  = zero_q;

endmodule
